life_evolver: RTL

Parametrised Game-of-Life generation engine for the GameOfLife design. It replaces the fixed 64×64 evolution block. It holds a double-buffered cell grid: the host writes and reads the visible (front) bank, and a step request computes the next generation one row per clock into the back bank, then swaps the banks. Grid size, edge mode and birth/survive rule are parameters, and the block reports generation and population counters.

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_row_update.sv | 43 ++++
 rtl/life_evolver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and rule helpers for the Game-of-Life generation engine.
// Holds the sequencer state encoding, the B3/S23 defaults and the cell rule.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam logic [8:0] BIRTH_B3    = 9'b000001000;
  localparam logic [8:0] SURVIVE_S23 = 9'b000001100;

  // A live cell consults the survive mask, a dead one the birth mask;
  // bit n of the mask is the outcome for n live neighbours.
  function automatic logic next_cell(
    input logic       alive,
    input logic [3:0] n,
    input logic [8:0] birth,
    input logic [8:0] survive
  );
    logic [8:0] mask;
    mask = alive ? survive : birth;
    return (n <= 4'd8) ? mask[n] : 1'b0;
  endfunction

endpackage

// File: rtl/life_row_update.sv
// Combinational next-generation row: one cell per column from three
// neighbouring rows, plus the live-cell count of the resulting row.
module life_row_update
  import life_pkg::*;
#(
  parameter int         COL_BITS = 6,
  parameter int         WRAP     = 1,
  parameter logic [8:0] BIRTH    = BIRTH_B3,
  parameter logic [8:0] SURVIVE  = SURVIVE_S23,
  localparam int        COLS     = 2 ** COL_BITS,
  localparam int        PW       = COL_BITS + 1
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] mid,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next_row,
  output logic [PW-1:0]   pop
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L    = (c == 0) ? COLS - 1 : c - 1;
    localparam int R    = (c == COLS - 1) ? 0 : c + 1;
    // Edge columns only see their wrapped partner on a torus.
    localparam bit L_OK = (WRAP != 0) || (c != 0);
    localparam bit R_OK = (WRAP != 0) || (c != COLS - 1);

    logic       use_l;
    logic       use_r;
    logic [7:0] nb;
    logic [3:0] n;

    assign use_l = L_OK;
    assign use_r = R_OK;
    assign nb = {above[c], below[c],
                 above[L] & use_l, mid[L] & use_l, below[L] & use_l,
                 above[R] & use_r, mid[R] & use_r, below[R] & use_r};
    assign n  = 4'($countones(nb));
    assign next_row[c] = next_cell(mid[c], n, BIRTH, SURVIVE);
  end

  assign pop = PW'($countones(next_row));

endmodule

// File: rtl/life_evolver.sv
// Double-buffered Game-of-Life engine: host owns the front bank, a step
// scans one row per clock into the back bank and then swaps banks.
module life_evolver
  import life_pkg::*;
#(
  parameter int         ROW_BITS = 6,
  parameter int         COL_BITS = 6,
  parameter int         WRAP     = 1,
  parameter logic [8:0] BIRTH    = BIRTH_B3,
  parameter logic [8:0] SURVIVE  = SURVIVE_S23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic [ROW_BITS-1:0]        wAddrR,
  input  logic [COL_BITS-1:0]        wAddrC,
  input  logic                       write_data,
  input  logic [ROW_BITS-1:0]        rAddrR,
  input  logic [COL_BITS-1:0]        rAddrC,
  output logic                       read_data,
  input  logic                       clear,
  input  logic                       step,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                gen_count,
  output logic [ROW_BITS+COL_BITS:0] alive_count
);

  localparam int ROWS  = 2 ** ROW_BITS;
  localparam int COLS  = 2 ** COL_BITS;
  localparam int ACC_W = ROW_BITS + COL_BITS + 1;

  logic [COLS-1:0]     bank [2][ROWS];
  logic                sel;
  state_t              state;
  state_t              next_state;
  logic [ROW_BITS-1:0] row;
  logic [ROW_BITS-1:0] row_prev;
  logic [ROW_BITS-1:0] row_next;
  logic                last_row;
  logic [ACC_W-1:0]    acc;

  logic                host_en;
  logic                scan_en;
  logic                swap_en;
  logic                start;

  logic [COLS-1:0]     above;
  logic [COLS-1:0]     mid;
  logic [COLS-1:0]     below;
  logic [COLS-1:0]     next_row;
  logic [COL_BITS:0]   pop;

  assign row_prev = row - ROW_BITS'(1);
  assign row_next = row + ROW_BITS'(1);
  assign last_row = (row == ROW_BITS'(ROWS - 1));
  assign start    = host_en & step;

  // Rows beyond the top/bottom edge read as dead unless the grid wraps.
  always_comb begin
    mid   = bank[sel][row];
    above = bank[sel][row_prev];
    below = bank[sel][row_next];
    if (WRAP == 0 && row == '0) above = '0;
    if (WRAP == 0 && last_row)  below = '0;
  end

  life_row_update #(
    .COL_BITS (COL_BITS),
    .WRAP     (WRAP),
    .BIRTH    (BIRTH),
    .SURVIVE  (SURVIVE)
  ) u_row (
    .above    (above),
    .mid      (mid),
    .below    (below),
    .next_row (next_row),
    .pop      (pop)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (step) next_state = SCAN;
      SCAN:    if (last_row) next_state = SWAP;
      SWAP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    host_en = (state == IDLE);
    scan_en = (state == SCAN);
    swap_en = (state == SWAP);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the banks are flops rather than RAM because reset and clear
      // must zero every cell in a single cycle.
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          bank[b][r] <= '0;
      sel         <= 1'b0;
      row         <= '0;
      acc         <= '0;
      gen_count   <= '0;
      alive_count <= '0;
      done        <= 1'b0;
      read_data   <= 1'b0;
    end else begin
      done      <= swap_en;
      read_data <= bank[sel][rAddrR][rAddrC];

      if (host_en) begin
        if (clear) begin
          for (int r = 0; r < ROWS; r++)
            bank[sel][r] <= '0;
        end else if (write_en) begin
          bank[sel][wAddrR][wAddrC] <= write_data;
        end
      end

      if (start) begin
        row <= '0;
        acc <= '0;
      end

      if (scan_en) begin
        bank[~sel][row] <= next_row;
        row             <= row_next;
        acc             <= acc + ACC_W'(pop);
      end

      if (swap_en) begin
        sel         <= ~sel;
        gen_count   <= gen_count + 16'd1;
        alive_count <= acc;
      end
    end
  end

endmodule
